// File: rtl/mdu.sv
// mdu: iterative 32-cycle MULT/MULTU/DIV/DIVU unit driving the HI/LO pair.
// The divider datapath is built only when MDU_DIV_EN is defined; otherwise DIV/DIVU report div_err.
module mdu #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] port_a,
  input  logic [WORD_W-1:0] port_b,
  output logic              busy,
  output logic              done,
  output logic              div_err,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo
);
  localparam int W  = WORD_W;
  localparam int CW = $clog2(W);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, bad_q, bad_d;
  logic           done_q, done_d, err_q, err_d;
  logic [W-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]   abs_a, abs_b, quot, rem;
  logic [2*W-1:0] p_q, p_d, step, prod;
  logic [W:0]     sum;
  logic           bad;

  assign abs_a = (op[0] && port_a[W-1]) ? -port_a : port_a;
  assign abs_b = (op[0] && port_b[W-1]) ? -port_b : port_b;
  // p_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
  assign sum   = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : '0);

`ifdef MDU_DIV_EN
  logic [W:0] diff;
  assign diff = p_q[2*W-1:W-1] - {1'b0, m_q};
  assign bad  = op[1] && port_b == '0;
  assign step = !div_q  ? {sum, p_q[W-1:1]} :
                diff[W] ? {p_q[2*W-2:0], 1'b0} :
                          {diff[W-1:0], p_q[W-2:0], 1'b1};
`else
  assign bad  = op[1];
  assign step = {sum, p_q[W-1:1]};
`endif

  assign prod = neg_q  ? -p_q          : p_q;
  assign quot = neg_q  ? -p_q[W-1:0]   : p_q[W-1:0];
  assign rem  = rneg_q ? -p_q[2*W-1:W] : p_q[2*W-1:W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    m_d     = m_q;
    p_d     = p_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bad_d   = bad_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q == IDLE && start) begin
      state_d = bad ? FIX : RUN;
      cnt_d   = '0;
      div_d   = op[1];
      bad_d   = bad;
      m_d     = op[1] ? abs_b : abs_a;
      p_d     = {{W{1'b0}}, op[1] ? abs_a : abs_b};
      neg_d   = op[0] & (port_a[W-1] ^ port_b[W-1]);
      rneg_d  = op[0] & port_a[W-1];
    end else if (state_q == RUN) begin
      p_d     = step;
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(W-1)) ? FIX : RUN;
    end else if (state_q == FIX) begin
      state_d = IDLE;
      done_d  = 1'b1;
      err_d   = bad_q;
      hi_d    = bad_q ? hi_q : div_q ? rem  : prod[2*W-1:W];
      lo_d    = bad_q ? lo_q : div_q ? quot : prod[W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      m_q     <= '0;
      p_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bad_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      m_q     <= m_d;
      p_q     <= p_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bad_q   <= bad_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy    = state_q != IDLE;
  assign done    = done_q;
  assign div_err = err_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized and directed checks of mdu against an arithmetic reference model.
module tb_mdu;
  logic        CLK = 1'b0, nRST = 1'b0, start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] port_a = '0, port_b = '0;
  logic        busy, done, div_err;
  logic [31:0] hi, lo;
  logic [31:0] mhi = '0, mlo = '0;
  int          n_chk = 0, n_pass = 0;
  bit          saw;

  mdu dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op), .port_a(port_a), .port_b(port_b),
    .busy(busy), .done(done), .div_err(div_err), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // returns {div_err, hi, lo} from plain arithmetic on the current HI/LO model
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    bit div_en;
`ifdef MDU_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'd0) begin
      p = {32'd0, a} * {32'd0, b};
      return {1'b0, p};
    end
    if (o == 2'd1) begin
      p = sa * sb;
      return {1'b0, p};
    end
    if (!div_en || b == 0) return {1'b1, mhi, mlo};
    if (o == 2'd2) return {1'b0, a % b, a / b};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [64:0] e;
    int lat, bcnt, exp_lat;
    bit stable;
    e = model(o, a, b);
    exp_lat = e[64] ? 1 : 33;
    @(negedge CLK);
    start = 1'b1; op = o; port_a = a; port_b = b;
    @(posedge CLK);
    #1 start = 1'b0; port_a = $urandom; port_b = $urandom;
    bcnt = busy; lat = 0; stable = 1'b1;
    while (lat < 40) begin
      start = poke && lat == 10;
      @(posedge CLK);
      #1 lat++;
      if (done) break;
      bcnt += busy;
      stable &= (hi == mhi && lo == mlo && !div_err);
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_cycles", 64'(bcnt), 64'(exp_lat));
    chk("hold_while_busy", 64'(stable), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("div_err", 64'(div_err), 64'(e[64]));
    chk("hi", 64'(hi), 64'(e[63:32]));
    chk("lo", 64'(lo), 64'(e[31:0]));
    mhi = e[63:32];
    mlo = e[31:0];
  endtask

  initial begin
    logic [31:0] a, b;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(div_err), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge CLK) nRST = 1'b1;

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'd1, 32'hFFFF_FFFD, 32'd5, 1'b1);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'd2, 32'd100, 32'd7, 1'b0);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
`ifdef MDU_DIV_EN
    run_op(2'd2, 32'h5678_1234, 32'h0001_0000, 1'b0);
    chk("preload", {hi, lo}, 64'h0000_1234_0000_5678);
`else
    run_op(2'd0, 32'h1234, 32'h0001_0000, 1'b0);
`endif
    run_op(2'd2, 32'd5, 32'd0, 1'b0);
    chk("div0_err", 64'(div_err), 64'd1);
    @(posedge CLK);
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("err_cleared", 64'(div_err), 64'd0);
    run_op(2'd3, 32'd10, 32'd3, 1'b0);
    run_op(2'd0, 32'd6, 32'd7, 1'b0);
    chk("multu_small", {hi, lo}, 64'd42);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 20);
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op(2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)));
    end

    @(negedge CLK);
    start = 1'b1; op = 2'd1; port_a = 32'h7654_3210; port_b = 32'h0123_4567;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (9) @(posedge CLK);
    #1 nRST = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    mhi = '0;
    mlo = '0;
    @(negedge CLK) nRST = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge CLK);
      #1 saw |= done | busy;
    end
    chk("no_done_after_abort", 64'(saw), 64'd0);
    run_op(2'd0, 32'd123456, 32'd654321, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
